wb_stage: RTL and testbench
===========================

# wb_stage

Writeback stage driving the register file write port (`rd_addr`/`rd_data`/`rd_wren`). It accepts completed results from the ALU path and the load path and arbitrates between them. It formats load data for RISC-V loads (LB/LH/LW/LBU/LHU) and registers a single write per cycle toward the register file. It also keeps a pending-load scoreboard so decode can stall reads of registers with an outstanding load.

## Interface
- No parameters (XLEN fixed at 32, 32 architectural registers).

- `i_clk` in 1 — global clock, all state on rising edge.
- `i_rst_n` in 1 — global reset, asynchronous, active-low.
- `i_alu_valid` in 1 — ALU result available.
- `i_alu_rd_addr` in 5 — ALU destination register.
- `i_alu_data` in 32 — ALU result.
- `o_alu_ready` out 1 — ALU result accepted this cycle when high with valid.
- `i_ld_valid` in 1 — load response available.
- `i_ld_rd_addr` in 5 — load destination register.
- `i_ld_funct3` in 3 — load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- `i_ld_byte_off` in 2 — address bits [1:0] of the load.
- `i_ld_rdata` in 32 — raw aligned memory word.
- `o_ld_ready` out 1 — load response accepted; constant 1.
- `i_issue_ld` in 1 — decode issued a load this cycle.
- `i_issue_rd_addr` in 5 — destination of the issued load.
- `o_pending` out 32 — bit n set: load to x{n} outstanding; bit 0 always 0.
- `o_rd_addr` out 5 — register file write address.
- `o_rd_data` out 32 — register file write data.
- `o_rd_wren` out 1 — register file write enable.
- `o_wb_count` out 32 — number of committed writes with wren=1, wraps modulo 2^32.
- `o_err` out 1 — sticky error flag, cleared only by reset.

## Operation
- Arbitration: the load path has priority. `o_ld_ready`=1 always. `o_alu_ready` = !`i_ld_valid`, combinational.
- Accept: ALU accepted when `i_alu_valid` && `o_alu_ready`. Load accepted when `i_ld_valid`.
- Load formatting (byte b = `i_ld_rdata`[8*off+7 : 8*off]; half h = bits [16*off[1]+15 : 16*off[1]]):
  - LB: sign-extend b. LBU: zero-extend b.
  - LH: sign-extend h. LHU: zero-extend h.
  - LW: full word.
- Load errors: unsupported `funct3`, or misalignment (LH/LHU with off[0]=1, LW with off≠0).
  - Write `o_rd_data`=0, still assert wren (if rd≠0).
  - Set `o_err`.
  - Still clear the pending bit.
- Write to x0: an accepted result with rd=0 is consumed; `o_rd_wren`=0, `o_wb_count` unchanged.
- Scoreboard:
  - `i_issue_ld` with rd≠0 sets `o_pending`[rd] on the next edge.
  - An accepted load response clears `o_pending`[ld_rd].
  - Issue and clear on the same register in the same cycle: set wins, since a new load is outstanding.
  - Issue with rd=0 is ignored.
- WAW check: an ALU result accepted to a register with `o_pending` set sets `o_err`, and the write still proceeds.
- Load response arriving for a non-pending register (rd≠0) sets `o_err`, and the write still proceeds.

## Timing
- Reset (async, immediate on `i_rst_n`=0):
  - `o_rd_wren`=0, `o_rd_addr`=0, `o_rd_data`=0.
  - `o_pending`=0, `o_wb_count`=0, `o_err`=0.
  - `o_alu_ready` follows its combinational equation.
- Latency: a result accepted at edge N appears on `o_rd_*` during cycle N→N+1. The register file captures it at edge N+1. `o_wb_count` increments at the same edge N as `o_rd_wren` rises.
- `o_rd_wren` is a one-cycle pulse per accepted write. With no acceptance it returns to 0 and addr/data hold their last value.
- Throughput: one write per cycle. Back-to-back loads starve the ALU, by design; the pipeline stalls upstream.
- `o_pending` changes one edge after issue/response. Decode compares against `o_pending` combinationally, so a response accepted at edge N unblocks decode in the cycle after N.
- Reset mid-operation: any in-flight `o_rd_wren` pulse is dropped and the scoreboard is cleared.

## Test plan
- Reset, then ALU valid rd=5, data=0x1234_5678 → next cycle `o_rd_wren`=1, addr=5, data=0x1234_5678; `o_wb_count`=1.
- Load rdata=0x80FF_7F01 with off 0..3:
  - LB → 0x01, 0x7F, 0xFFFFFFFF, 0xFFFFFF80.
  - LBU off=3 → 0x80.
  - LH off=2 → 0xFFFF80FF; LHU off=2 → 0x80FF.
  - LW off=0 → 0x80FF7F01.
- ALU and load valid in the same cycle (ALU rd=3, load rd=4) → `o_alu_ready`=0. Load written first; ALU written the next cycle after load valid drops.
- Scoreboard:
  - Issue load rd=7 → `o_pending`[7]=1.
  - Response and new issue to rd=7 in the same cycle → bit stays 1.
  - Next response → bit clears, `o_err`=0.
- Errors:
  - LW off=2 → data 0, `o_err`=1, sticky.
  - ALU to pending rd=7 → `o_err`=1.
  - ALU to rd=0 → `o_rd_wren`=0, count unchanged.
- Assert `i_rst_n`=0 during a `o_rd_wren` pulse with `o_pending`=0x0000_0080 → all outputs 0 immediately, no write observed.

Source files
------------

// File: rtl/wb_stage.sv
// Writeback stage: arbitrates ALU/load results, formats load data, registers one
// register-file write per cycle and tracks outstanding loads for decode stalls.
module wb_stage (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_alu_valid,
  input  logic [4:0]  i_alu_rd_addr,
  input  logic [31:0] i_alu_data,
  output logic        o_alu_ready,
  input  logic        i_ld_valid,
  input  logic [4:0]  i_ld_rd_addr,
  input  logic [2:0]  i_ld_funct3,
  input  logic [1:0]  i_ld_byte_off,
  input  logic [31:0] i_ld_rdata,
  output logic        o_ld_ready,
  input  logic        i_issue_ld,
  input  logic [4:0]  i_issue_rd_addr,
  output logic [31:0] o_pending,
  output logic [4:0]  o_rd_addr,
  output logic [31:0] o_rd_data,
  output logic        o_rd_wren,
  output logic [31:0] o_wb_count,
  output logic        o_err
);

  logic        r_rd_wren;
  logic [4:0]  r_rd_addr;
  logic [31:0] r_rd_data;
  logic [31:0] r_pending;
  logic [31:0] r_wb_count;
  logic        r_err;

  logic        w_alu_acc;
  logic        w_ld_acc;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ld_fmt;
  logic        w_ld_bad;
  logic [4:0]  w_wr_addr;
  logic [31:0] w_wr_data;
  logic        w_wr_en;
  logic        w_err_set;
  logic [31:0] w_pending_nxt;

  // Loads always win; the ALU path simply waits upstream.
  assign o_ld_ready  = 1'b1;
  assign o_alu_ready = !i_ld_valid;
  assign w_ld_acc    = i_ld_valid;
  assign w_alu_acc   = i_alu_valid && !i_ld_valid;

  always_comb begin
    w_byte   = '0;
    w_ld_fmt = '0;
    w_ld_bad = 1'b0;
    case (i_ld_byte_off)
      2'd0:    w_byte = i_ld_rdata[7:0];
      2'd1:    w_byte = i_ld_rdata[15:8];
      2'd2:    w_byte = i_ld_rdata[23:16];
      default: w_byte = i_ld_rdata[31:24];
    endcase
    w_half = i_ld_byte_off[1] ? i_ld_rdata[31:16] : i_ld_rdata[15:0];
    case (i_ld_funct3)
      3'b000: w_ld_fmt = {{24{w_byte[7]}}, w_byte};
      3'b100: w_ld_fmt = {24'd0, w_byte};
      3'b001: begin
        w_ld_bad = i_ld_byte_off[0];
        w_ld_fmt = {{16{w_half[15]}}, w_half};
      end
      3'b101: begin
        w_ld_bad = i_ld_byte_off[0];
        w_ld_fmt = {16'd0, w_half};
      end
      3'b010: begin
        w_ld_bad = (i_ld_byte_off != 2'd0);
        w_ld_fmt = i_ld_rdata;
      end
      default: w_ld_bad = 1'b1;
    endcase
  end

  always_comb begin
    w_wr_addr = '0;
    w_wr_data = '0;
    w_wr_en   = 1'b0;
    w_err_set = 1'b0;
    if (w_ld_acc) begin
      w_wr_addr = i_ld_rd_addr;
      w_wr_data = w_ld_bad ? 32'd0 : w_ld_fmt;
      w_wr_en   = (i_ld_rd_addr != 5'd0);
      w_err_set = w_ld_bad || ((i_ld_rd_addr != 5'd0) && !r_pending[i_ld_rd_addr]);
    end else if (w_alu_acc) begin
      w_wr_addr = i_alu_rd_addr;
      w_wr_data = i_alu_data;
      w_wr_en   = (i_alu_rd_addr != 5'd0);
      w_err_set = r_pending[i_alu_rd_addr];
    end
  end

  // Clear first, then set, so a same-cycle reissue keeps the bit outstanding.
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_ld_acc)
      w_pending_nxt[i_ld_rd_addr] = 1'b0;
    if (i_issue_ld && (i_issue_rd_addr != 5'd0))
      w_pending_nxt[i_issue_rd_addr] = 1'b1;
    w_pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_wren  <= 1'b0;
      r_rd_addr  <= '0;
      r_rd_data  <= '0;
      r_pending  <= '0;
      r_wb_count <= '0;
      r_err      <= 1'b0;
    end else begin
      r_rd_wren <= w_wr_en;
      if (w_wr_en) begin
        r_rd_addr  <= w_wr_addr;
        r_rd_data  <= w_wr_data;
        r_wb_count <= r_wb_count + 32'd1;
      end
      r_pending <= w_pending_nxt;
      if (w_err_set)
        r_err <= 1'b1;
    end
  end

  assign o_rd_wren  = r_rd_wren;
  assign o_rd_addr  = r_rd_addr;
  assign o_rd_data  = r_rd_data;
  assign o_pending  = r_pending;
  assign o_wb_count = r_wb_count;
  assign o_err      = r_err;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: expected writes queued on acceptance and
// popped by a negedge monitor whenever the register-file write enable is seen.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        alu_ready;
  logic        ld_valid = 1'b0;
  logic [4:0]  ld_rd = '0;
  logic [2:0]  ld_f3 = '0;
  logic [1:0]  ld_off = '0;
  logic [31:0] ld_rdata = '0;
  logic        ld_ready;
  logic        issue = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic [31:0] pending;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_wren;
  logic [31:0] wb_count;
  logic        err;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [36:0] sb_q[$];
  logic [31:0] cnt_snap;

  wb_stage dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_alu_valid(alu_valid), .i_alu_rd_addr(alu_rd), .i_alu_data(alu_data),
    .o_alu_ready(alu_ready),
    .i_ld_valid(ld_valid), .i_ld_rd_addr(ld_rd), .i_ld_funct3(ld_f3),
    .i_ld_byte_off(ld_off), .i_ld_rdata(ld_rdata), .o_ld_ready(ld_ready),
    .i_issue_ld(issue), .i_issue_rd_addr(issue_rd),
    .o_pending(pending), .o_rd_addr(rd_addr), .o_rd_data(rd_data),
    .o_rd_wren(rd_wren), .o_wb_count(wb_count), .o_err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ld_model(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] w);
    logic [31:0] sb;
    logic [31:0] sh;
    sb = w >> (8 * off);
    sh = w >> (16 * off[1]);
    case (f3)
      3'b000: return {{24{sb[7]}}, sb[7:0]};
      3'b100: return {24'd0, sb[7:0]};
      3'b001: return off[0] ? 32'd0 : {{16{sh[15]}}, sh[15:0]};
      3'b101: return off[0] ? 32'd0 : {16'd0, sh[15:0]};
      3'b010: return (off != 2'd0) ? 32'd0 : w;
      default: return 32'd0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && rd_wren) begin
      if (sb_q.size() == 0) begin
        check("unexpected_write", {27'd0, rd_addr}, 32'd0);
      end else begin
        logic [36:0] e;
        e = sb_q.pop_front();
        check("wr_addr", {27'd0, rd_addr}, {27'd0, e[36:32]});
        check("wr_data", rd_data, e[31:0]);
      end
    end
  end

  // Issue a load to rd, then return its response the following cycle.
  task automatic do_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off,
                         input logic [31:0] w);
    step();
    issue = 1'b1; issue_rd = rd;
    step();
    issue = 1'b0;
    ld_valid = 1'b1; ld_rd = rd; ld_f3 = f3; ld_off = off; ld_rdata = w;
    if (rd != 5'd0) sb_q.push_back({rd, ld_model(f3, off, w)});
    step();
    ld_valid = 1'b0;
  endtask

  task automatic do_alu(input logic [4:0] rd, input logic [31:0] d);
    step();
    alu_valid = 1'b1; alu_rd = rd; alu_data = d;
    if (rd != 5'd0) sb_q.push_back({rd, d});
    step();
    alu_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    check("rst_wren", {31'd0, rd_wren}, 32'd0);
    check("rst_addr", {27'd0, rd_addr}, 32'd0);
    check("rst_data", rd_data, 32'd0);
    check("rst_pending", pending, 32'd0);
    check("rst_count", wb_count, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_alu_ready", {31'd0, alu_ready}, 32'd1);
    check("ld_ready", {31'd0, ld_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    do_alu(5'd5, 32'h1234_5678);
    check("count_after_alu", wb_count, 32'd1);

    for (int unsigned o = 0; o < 4; o++) do_load(5'd6, 3'b000, o[1:0], 32'h80FF_7F01);
    do_load(5'd6, 3'b100, 2'd3, 32'h80FF_7F01);
    do_load(5'd6, 3'b001, 2'd2, 32'h80FF_7F01);
    do_load(5'd6, 3'b101, 2'd2, 32'h80FF_7F01);
    do_load(5'd6, 3'b010, 2'd0, 32'h80FF_7F01);
    check("err_after_fmt", {31'd0, err}, 32'd0);
    check("count_after_fmt", wb_count, 32'd9);

    // Simultaneous ALU and load: load first, ALU the cycle after.
    step();
    issue = 1'b1; issue_rd = 5'd4;
    step();
    issue = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hA5A5_0003;
    ld_valid = 1'b1; ld_rd = 5'd4; ld_f3 = 3'b010; ld_off = 2'd0; ld_rdata = 32'hDEAD_0004;
    #1;
    check("alu_ready_blocked", {31'd0, alu_ready}, 32'd0);
    sb_q.push_back({5'd4, 32'hDEAD_0004});
    step();
    ld_valid = 1'b0;
    #1;
    check("alu_ready_free", {31'd0, alu_ready}, 32'd1);
    sb_q.push_back({5'd3, 32'hA5A5_0003});
    step();
    alu_valid = 1'b0;

    // Scoreboard on x7.
    step();
    issue = 1'b1; issue_rd = 5'd7;
    step();
    issue = 1'b0;
    check("pend_set", pending, 32'h0000_0080);
    ld_valid = 1'b1; ld_rd = 5'd7; ld_f3 = 3'b010; ld_off = 2'd0; ld_rdata = 32'h0000_0777;
    issue = 1'b1; issue_rd = 5'd7;
    sb_q.push_back({5'd7, 32'h0000_0777});
    step();
    ld_valid = 1'b0; issue = 1'b0;
    check("pend_set_wins", pending, 32'h0000_0080);
    ld_valid = 1'b1; ld_rd = 5'd7; ld_rdata = 32'h0000_0778;
    sb_q.push_back({5'd7, 32'h0000_0778});
    step();
    ld_valid = 1'b0;
    check("pend_clear", pending, 32'h0000_0000);
    check("err_after_sb", {31'd0, err}, 32'd0);

    // Write to x0 is swallowed.
    cnt_snap = wb_count;
    do_alu(5'd0, 32'hFFFF_FFFF);
    check("x0_wren", {31'd0, rd_wren}, 32'd0);
    step();
    check("x0_count", wb_count, cnt_snap);

    // WAW: ALU to a register with a load outstanding.
    step();
    issue = 1'b1; issue_rd = 5'd7;
    step();
    issue = 1'b0;
    check("err_before_waw", {31'd0, err}, 32'd0);
    do_alu(5'd7, 32'h0000_00AA);
    check("err_waw", {31'd1, err} & 32'd1, 32'd1);
    check("pend_after_waw", pending, 32'h0000_0080);

    // Reset in the middle of a write pulse.
    step();
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h0000_0999;
    step();
    alu_valid = 1'b0;
    check("pulse_before_rst", {31'd0, rd_wren}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_wren", {31'd0, rd_wren}, 32'd0);
    check("midrst_addr", {27'd0, rd_addr}, 32'd0);
    check("midrst_data", rd_data, 32'd0);
    check("midrst_pending", pending, 32'd0);
    check("midrst_count", wb_count, 32'd0);
    check("midrst_err", {31'd0, err}, 32'd0);
    step();
    step();
    @(negedge clk);
    rst_n = 1'b1;

    // Misaligned LW and unsupported funct3 produce zero data and a sticky error.
    do_load(5'd10, 3'b010, 2'd2, 32'h1357_9BDF);
    check("err_lw_misalign", {31'd0, err}, 32'd1);
    do_alu(5'd11, 32'h0000_0B0B);
    step();
    check("err_sticky", {31'd0, err}, 32'd1);
    do_load(5'd12, 3'b011, 2'd0, 32'h2468_ACE0);
    check("count_end", wb_count, 32'd3);

    step();
    step();
    check("sb_empty", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
